// File: rtl/motor_pwm_drv.sv
// H-bridge motor driver: PWM enable generation, level ramping, and a brake dead-time
// that every stop or direction reversal passes through before the bridge is reused.
module motor_pwm_drv #(
  parameter int unsigned PRESCALE         = 100,
  parameter int unsigned RAMP_PERIODS     = 10,
  parameter int unsigned DEADTIME_PERIODS = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_run,
  input  logic [3:0] i_level,
  input  logic [1:0] i_dir,
  output logic       o_pwm,
  output logic [1:0] o_in1_in2,
  output logic [3:0] o_level,
  output logic       o_busy
);

  localparam int unsigned PsW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned RampW = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;
  localparam int unsigned DeadW = (DEADTIME_PERIODS > 1) ? $clog2(DEADTIME_PERIODS) : 1;

  localparam logic [PsW-1:0]   PsLast   = PsW'(PRESCALE - 1);
  localparam logic [RampW-1:0] RampLast = RampW'(RAMP_PERIODS - 1);
  localparam logic [DeadW-1:0] DeadLast = DeadW'(DEADTIME_PERIODS - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StStopping,
    StDead
  } state_e;

  state_e           state_q, state_d;
  logic [PsW-1:0]   prescale_q;
  logic [6:0]       pcnt_q;
  logic [RampW-1:0] ramp_cnt_q, ramp_cnt_d;
  logic [DeadW-1:0] dead_cnt_q, dead_cnt_d;
  logic [3:0]       cur_level_q, cur_level_d;
  logic [1:0]       dir_q, dir_d;
  logic             pwm_q, pwm_d;
  logic [1:0]       hb_q, hb_d;

  logic       tick;
  logic       period_end;
  logic       dir_valid;
  logic       state_change;
  logic [3:0] level_clamped;
  logic [3:0] target;
  logic [6:0] duty;

  assign tick          = (prescale_q == PsLast);
  assign period_end    = tick && (pcnt_q == 7'd99);
  assign dir_valid     = (i_dir == 2'b01) || (i_dir == 2'b10);
  assign level_clamped = (i_level > 4'd10) ? 4'd10 : i_level;
  assign duty          = 7'(cur_level_q) * 7'd10;

  // Timebase: free-running prescaler and 100-tick PWM period counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescale_q <= '0;
      pcnt_q     <= '0;
    end else begin
      prescale_q <= tick ? '0 : prescale_q + 1'b1;
      if (tick) begin
        pcnt_q <= (pcnt_q == 7'd99) ? 7'd0 : pcnt_q + 7'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    target  = 4'd0;
    case (state_q)
      StIdle: begin
        if (i_run && dir_valid) begin
          state_d = StRun;
          dir_d   = i_dir;
        end
      end
      StRun: begin
        target = level_clamped;
        if (!i_run || !dir_valid || (i_dir != dir_q)) begin
          state_d = StStopping;
        end
      end
      StStopping: begin
        if (period_end && (cur_level_q == 4'd0)) begin
          state_d = StDead;
        end
      end
      StDead: begin
        if (period_end && (dead_cnt_q == DeadLast)) begin
          if (i_run && dir_valid) begin
            state_d = StRun;
            dir_d   = i_dir;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign state_change = (state_d != state_q);

  // Ramp and dead-time counters restart on every state entry; no level step on a leaving cycle.
  always_comb begin
    ramp_cnt_d  = ramp_cnt_q;
    dead_cnt_d  = dead_cnt_q;
    cur_level_d = cur_level_q;
    if (state_change) begin
      ramp_cnt_d = '0;
      dead_cnt_d = '0;
    end else if (period_end) begin
      if ((state_q == StRun) || (state_q == StStopping)) begin
        if (ramp_cnt_q == RampLast) begin
          ramp_cnt_d = '0;
          if (cur_level_q < target) begin
            cur_level_d = cur_level_q + 4'd1;
          end else if (cur_level_q > target) begin
            cur_level_d = cur_level_q - 4'd1;
          end
        end else begin
          ramp_cnt_d = ramp_cnt_q + 1'b1;
        end
      end
      if (state_q == StDead) begin
        dead_cnt_d = dead_cnt_q + 1'b1;
      end
    end
    if (state_q == StIdle) begin
      cur_level_d = 4'd0;
    end
  end

  // Bridge code follows the next state so it changes on the same edge as the state.
  always_comb begin
    hb_d = 2'b00;
    case (state_d)
      StRun, StStopping: hb_d = (dir_d == 2'b10) ? 2'b01 : 2'b10;
      StDead:            hb_d = 2'b11;
      default:           hb_d = 2'b00;
    endcase
    pwm_d = (state_q != StDead) && (pcnt_q < duty);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      ramp_cnt_q  <= '0;
      dead_cnt_q  <= '0;
      cur_level_q <= 4'd0;
      dir_q       <= 2'b01;
      pwm_q       <= 1'b0;
      hb_q        <= 2'b00;
    end else begin
      state_q     <= state_d;
      ramp_cnt_q  <= ramp_cnt_d;
      dead_cnt_q  <= dead_cnt_d;
      cur_level_q <= cur_level_d;
      dir_q       <= dir_d;
      pwm_q       <= pwm_d;
      hb_q        <= hb_d;
    end
  end

  assign o_pwm     = pwm_q;
  assign o_in1_in2 = hb_q;
  assign o_level   = cur_level_q;
  assign o_busy    = (state_q != StIdle);

endmodule

// File: tb/tb_motor_pwm_drv.sv
// Bench for motor_pwm_drv: directed scenarios plus random run/level/direction segments,
// every cycle compared against a behavioural model of the driver.
module tb_motor_pwm_drv;

  localparam int RAMP = 1;
  localparam int DEAD = 2;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_STOP = 2;
  localparam int M_DEAD = 3;

  logic       clk;
  logic       reset;
  logic       i_run;
  logic [3:0] i_level;
  logic [1:0] i_dir;
  logic       o_pwm;
  logic [1:0] o_in1_in2;
  logic [3:0] o_level;
  logic       o_busy;

  int n_tests;
  int n_fail;

  // Behavioural model state; with PRESCALE = 1 every clock is a PWM tick.
  int m_cyc;
  int m_mode;
  int m_dir;
  int m_level;
  int m_ramp_pes;
  int m_dead_pes;
  int m_pwm;
  int m_hb;

  motor_pwm_drv #(
    .PRESCALE        (1),
    .RAMP_PERIODS    (RAMP),
    .DEADTIME_PERIODS(DEAD)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .i_run    (i_run),
    .i_level  (i_level),
    .i_dir    (i_dir),
    .o_pwm    (o_pwm),
    .o_in1_in2(o_in1_in2),
    .o_level  (o_level),
    .o_busy   (o_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cyc      = 0;
    m_mode     = M_IDLE;
    m_dir      = 1;
    m_level    = 0;
    m_ramp_pes = 0;
    m_dead_pes = 0;
    m_pwm      = 0;
    m_hb       = 0;
  endtask

  // One clock edge of the driver, from the rules: phase = ticks mod 100, level moves one step
  // per RAMP period ends, stop/dead sequencing, bridge code of the mode being entered.
  task automatic model_step();
    int  phase;
    bit  pe;
    bit  valid;
    int  tgt;
    int  nmode;
    int  ndir;
    phase = m_cyc % 100;
    pe    = (phase == 99);
    valid = (i_dir == 2'b01) || (i_dir == 2'b10);
    tgt   = (m_mode == M_RUN) ? ((int'(i_level) > 10) ? 10 : int'(i_level)) : 0;
    nmode = m_mode;
    ndir  = m_dir;
    if (m_mode == M_IDLE) begin
      if (i_run && valid) begin
        nmode = M_RUN;
        ndir  = int'(i_dir);
      end
    end else if (m_mode == M_RUN) begin
      if (!i_run || !valid || (int'(i_dir) != m_dir)) nmode = M_STOP;
    end else if (m_mode == M_STOP) begin
      if (pe && (m_level == 0)) nmode = M_DEAD;
    end else begin
      if (pe && (m_dead_pes + 1 == DEAD)) begin
        if (i_run && valid) begin
          nmode = M_RUN;
          ndir  = int'(i_dir);
        end else begin
          nmode = M_IDLE;
        end
      end
    end
    m_pwm = ((m_mode != M_DEAD) && (phase < m_level * 10)) ? 1 : 0;
    if (nmode != m_mode) begin
      m_ramp_pes = 0;
      m_dead_pes = 0;
    end else if (pe) begin
      if ((m_mode == M_RUN) || (m_mode == M_STOP)) begin
        m_ramp_pes++;
        if (m_ramp_pes % RAMP == 0) begin
          if (m_level < tgt) m_level++;
          else if (m_level > tgt) m_level--;
        end
      end else if (m_mode == M_DEAD) begin
        m_dead_pes++;
      end
    end
    m_mode = nmode;
    m_dir  = ndir;
    if (m_mode == M_IDLE) m_level = 0;
    if (m_mode == M_IDLE) m_hb = 0;
    else if (m_mode == M_DEAD) m_hb = 3;
    else m_hb = (m_dir == 2) ? 1 : 2;
    m_cyc++;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    chk("pwm", 8'(o_pwm), 8'(m_pwm));
    chk("in1_in2", 8'(o_in1_in2), 8'(m_hb));
    chk("level", 8'(o_level), 8'(m_level));
    chk("busy", 8'(o_busy), (m_mode != M_IDLE) ? 8'd1 : 8'd0);
  endtask

  task automatic run_cycles(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic count_pwm_high(output int highs);
    highs = 0;
    for (int k = 0; k < 100; k++) begin
      cycle();
      if (o_pwm === 1'b1) highs++;
    end
  endtask

  task automatic set_in(input logic run, input logic [3:0] lvl, input logic [1:0] dir);
    i_run   = run;
    i_level = lvl;
    i_dir   = dir;
  endtask

  initial begin
    int highs;
    int saw_brake;
    logic [1:0] dir_tbl [4];
    n_tests = 0;
    n_fail  = 0;
    dir_tbl[0] = 2'b01;
    dir_tbl[1] = 2'b10;
    dir_tbl[2] = 2'b00;
    dir_tbl[3] = 2'b11;

    reset = 1'b1;
    set_in(1'b0, 4'd0, 2'b00);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_pwm", 8'(o_pwm), 8'd0);
    chk("reset_in1_in2", 8'(o_in1_in2), 8'd0);
    chk("reset_level", 8'(o_level), 8'd0);
    chk("reset_busy", 8'(o_busy), 8'd0);
    @(negedge clk);
    reset = 1'b0;

    // Invalid direction with run: stays idle.
    set_in(1'b1, 4'd5, 2'b11);
    run_cycles(300);
    chk("invalid_dir_busy", 8'(o_busy), 8'd0);
    chk("invalid_dir_in1_in2", 8'(o_in1_in2), 8'd0);

    // Forward start to level 3.
    set_in(1'b1, 4'd3, 2'b01);
    cycle();
    chk("start_busy", 8'(o_busy), 8'd1);
    chk("start_in1_in2", 8'(o_in1_in2), 8'd2);
    run_cycles(500);
    chk("fwd_level3", 8'(o_level), 8'd3);
    count_pwm_high(highs);
    chk("fwd_duty30", 8'(highs), 8'd30);

    // Reversal: ramp down, brake for two periods, ramp up in reverse.
    set_in(1'b1, 4'd3, 2'b10);
    saw_brake = 0;
    for (int k = 0; k < 1100; k++) begin
      cycle();
      if (o_in1_in2 === 2'b11) begin
        saw_brake++;
        if (o_pwm !== 1'b0) chk("brake_pwm_low", 8'(o_pwm), 8'd0);
      end
    end
    chk("rev_brake_len", 8'(saw_brake), 8'd200);
    chk("rev_in1_in2", 8'(o_in1_in2), 8'd1);
    chk("rev_level3", 8'(o_level), 8'd3);

    // Level above 10 saturates.
    set_in(1'b1, 4'd15, 2'b10);
    run_cycles(1000);
    chk("sat_level10", 8'(o_level), 8'd10);
    count_pwm_high(highs);
    chk("sat_duty100", 8'(highs), 8'd100);

    // Down to 2, then drop run: ends idle.
    set_in(1'b1, 4'd2, 2'b10);
    run_cycles(1000);
    chk("down_level2", 8'(o_level), 8'd2);
    set_in(1'b0, 4'd2, 2'b10);
    run_cycles(800);
    chk("stop_busy", 8'(o_busy), 8'd0);
    chk("stop_in1_in2", 8'(o_in1_in2), 8'd0);
    chk("stop_level", 8'(o_level), 8'd0);

    // Random segments.
    for (int s = 0; s < 25; s++) begin
      set_in(($urandom % 4) != 0, 4'($urandom % 16), dir_tbl[$urandom % 4]);
      run_cycles(int'($urandom_range(20, 600)));
    end

    // Settle, run to level 5, then reset mid-run.
    set_in(1'b0, 4'd0, 2'b01);
    run_cycles(1600);
    set_in(1'b1, 4'd5, 2'b01);
    run_cycles(800);
    chk("pre_reset_level5", 8'(o_level), 8'd5);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_pwm", 8'(o_pwm), 8'd0);
    chk("async_rst_level", 8'(o_level), 8'd0);
    chk("async_rst_in1_in2", 8'(o_in1_in2), 8'd0);
    chk("async_rst_busy", 8'(o_busy), 8'd0);
    set_in(1'b0, 4'd5, 2'b01);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    run_cycles(200);
    chk("post_reset_idle", 8'(o_busy), 8'd0);
    set_in(1'b1, 4'd4, 2'b10);
    run_cycles(600);
    chk("post_reset_rev_level", 8'(o_level), 8'd4);
    chk("post_reset_rev_in1_in2", 8'(o_in1_in2), 8'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/motor_pwm_drv.md
MOTOR_PWM_DRV -- requirements
Module: motor_pwm_drv

Interface
REQ-001 SHALL have parameter PRESCALE, default 100, the number of clk cycles per PWM tick (100 MHz clk gives a 1 MHz tick).
REQ-002 SHALL have parameter RAMP_PERIODS, default 10, the number of PWM periods per one-level ramp step.
REQ-003 SHALL have parameter DEADTIME_PERIODS, default 5, the number of PWM periods in brake dead-time.
REQ-004 SHALL have port clk, input, 1 bit, the single system clock; all logic is in this one clock domain.
REQ-005 SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-006 SHALL have port i_run, input, 1 bit, the level-sensitive run request from the controller FSM.
REQ-007 SHALL have port i_level, input, 4 bits, the target speed level 0..10; values above 10 are clamped to 10.
REQ-008 SHALL have port i_dir, input, 2 bits, the direction switches: 01 = forward, 10 = reverse, 00/11 = invalid (stop).
REQ-009 SHALL have port o_pwm, output, 1 bit, the motor enable PWM (registered).
REQ-010 SHALL have port o_in1_in2, output, 2 bits, the H-bridge inputs: 10 = forward, 01 = reverse, 00 = coast, 11 = brake (registered).
REQ-011 SHALL have port o_level, output, 4 bits, the currently applied level 0..10 (registered).
REQ-012 SHALL have port o_busy, output, 1 bit, which is high whenever the state is not IDLE.

Function
REQ-013 SHALL generate tick one cycle every PRESCALE clk cycles from a free-running prescaler.
REQ-014 SHALL keep period counter pcnt 0..99, advancing on tick and wrapping 99 -> 0; period_end = tick while pcnt == 99.
REQ-015 SHALL drive o_pwm = (pcnt < cur_level*10), registered, giving level 0 -> constant low, level 10 -> constant high, and 10% duty per level.
REQ-016 SHALL change cur_level only on period_end, so there are no partial or glitched PWM periods.
REQ-017 SHALL implement FSM states IDLE, RUN, STOPPING, DEAD.
REQ-018 In IDLE: o_in1_in2 = 00, cur_level = 0, and on i_run = 1 with valid i_dir it SHALL latch dir_q = i_dir and go to RUN on the next cycle.
REQ-019 In RUN: target = clamp(i_level), and every RAMP_PERIODS period_ends cur_level SHALL move by exactly 1 toward target (never overshoot; hold when equal).
REQ-020 In RUN, if i_run = 0, or i_dir is invalid, or i_dir is valid and differs from dir_q, the FSM SHALL go to STOPPING.
REQ-021 In STOPPING: target = 0, ramping per REQ-019 continues, o_in1_in2 keeps dir_q, and when cur_level = 0 at period_end the FSM SHALL go to DEAD.
REQ-022 In DEAD: o_in1_in2 = 11, o_pwm = 0, and the block SHALL count DEADTIME_PERIODS period_ends, then go to RUN with dir_q = i_dir if i_run is high and i_dir is valid, else go to IDLE.
REQ-023 In RUN and STOPPING, o_in1_in2 SHALL be 10 for dir_q = 01 and 01 for dir_q = 10.
REQ-024 Inputs arriving in STOPPING or DEAD SHALL NOT shorten ramp-down or dead-time; a direction reversal always passes through level 0 and brake.
REQ-025 i_level changes in RUN SHALL retarget the ramp at the next ramp step with no other side effect.
REQ-026 The ramp step counter SHALL reset to 0 on every state entry.

Reset
REQ-027 On reset assertion, asynchronously: state = IDLE, prescaler = 0, pcnt = 0, ramp and dead counters = 0, cur_level = 0, dir_q = 01, o_pwm = 0, o_in1_in2 = 00, o_level = 0, o_busy = 0.
REQ-028 Reset asserted mid-run SHALL force the outputs of REQ-027 immediately, with no ramp-down or brake; after release the block waits in IDLE for i_run.

Verification (PRESCALE=1, RAMP_PERIODS=1, DEADTIME_PERIODS=2; one period = 100 clk)
REQ-029 i_run = 1, i_dir = 01, i_level = 3 from IDLE -> o_busy rises next cycle; o_in1_in2 = 10; o_level steps 1, 2, 3 at successive period_ends; final o_pwm high 30 of every 100 clk.
REQ-030 At level 3, i_dir -> 10 -> o_level 2, 1, 0; then o_in1_in2 = 11 for 200 clk with o_pwm = 0; then o_in1_in2 = 01 and ramp up to 3.
REQ-031 i_level = 15 -> o_level saturates at 10 and o_pwm stays constantly high.
REQ-032 i_run dropped at level 2 -> o_level 1, 0, then DEAD for 2 periods, then IDLE with o_in1_in2 = 00 and o_busy = 0.
REQ-033 i_dir = 11 with i_run = 1 in IDLE -> the block stays IDLE and all outputs stay 0.
REQ-034 Reset pulse while at level 5 -> o_pwm, o_level and o_in1_in2 are 0 in the same cycle, without waiting for a clk edge.
